led_pattern_sequencer: RTL and testbench

Status-LED controller for the board's LED bank. It owns the enable of the tick-generating clock divider, consumes the divider's one-cycle `tick`, and drives the LED pattern for four modes: idle, busy-chase, done-flash and error-blink. Mode changes come from calculator core status events. It restarts the divider phase on every mode entry, so each pattern's first step lasts exactly one full divider period.

---
 rtl/led_pattern_sequencer.sv | 144 ++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - status-LED pattern sequencer driving the divider enable
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   tick_i         one-cycle pulse from the clock divider
//   busy_i         level, core is computing
//   done_i         pulse, operation completed
//   error_i        pulse, operation failed
//   error_clear_i  pulse, user acknowledges the error
//   div_enable_o   divider enable; low clears the divider counter
//   leds_o         registered LED drive
//   state_o        current mode: IDLE=0, CHASE=1, DONE=2, ERROR=3
module led_pattern_sequencer #(
  parameter int LED_WIDTH    = 16,
  parameter int DONE_FLASHES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_i,
  input  logic                 busy_i,
  input  logic                 done_i,
  input  logic                 error_i,
  input  logic                 error_clear_i,
  output logic                 div_enable_o,
  output logic [LED_WIDTH-1:0] leds_o,
  output logic [1:0]           state_o
);

  localparam int CW = $clog2(DONE_FLASHES + 1);
  localparam logic [CW-1:0] FLASH_LAST = CW'(DONE_FLASHES);
  localparam logic [LED_WIDTH-1:0] ALL_ON = {LED_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHASE = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_t;

  state_t               state, state_n, target;
  logic [LED_WIDTH-1:0] leds_n;
  logic [CW-1:0]        flash_cnt, flash_cnt_n;
  logic                 div_en_n;
  logic                 go;
  logic                 tick_ok;

  // The enable is low in IDLE and in every entry cycle, so it doubles as the
  // "tick may be accepted" qualifier.
  assign tick_ok = tick_i & div_enable_o;

  always_comb begin
    state_n     = state;
    leds_n      = leds_o;
    flash_cnt_n = flash_cnt;
    div_en_n    = (state != IDLE);
    go          = 1'b0;
    target      = state;

    case (state)
      IDLE: begin
        leds_n = '0;
        if (error_i) begin
          go = 1'b1; target = ERROR;
        end else if (done_i) begin
          go = 1'b1; target = DONE;
        end else if (busy_i) begin
          go = 1'b1; target = CHASE;
        end
      end
      CHASE: begin
        if (error_i) begin
          go = 1'b1; target = ERROR;
        end else if (done_i) begin
          go = 1'b1; target = DONE;
        end else if (!busy_i) begin
          go = 1'b1; target = IDLE;
        end else if (tick_ok) begin
          leds_n = {leds_o[LED_WIDTH-2:0], leds_o[LED_WIDTH-1]};
        end
      end
      DONE: begin
        if (error_i) begin
          go = 1'b1; target = ERROR;
        end else if (done_i) begin
          go = 1'b1; target = DONE;  // re-entry restarts pattern and counter
        end else if (tick_ok) begin
          if (leds_o == ALL_ON) begin
            leds_n      = '0;
            flash_cnt_n = flash_cnt + CW'(1);
          end else if (flash_cnt != FLASH_LAST) begin
            leds_n = ALL_ON;
          end else begin
            go     = 1'b1;
            target = busy_i ? CHASE : IDLE;
          end
        end
      end
      ERROR: begin
        // A repeated error_i is not an event here; the blink keeps running.
        if (error_clear_i && !error_i) begin
          go = 1'b1; target = IDLE;
        end else if (tick_ok) begin
          leds_n = ~leds_o;
        end
      end
      default: begin
        go = 1'b1; target = IDLE;
      end
    endcase

    // Every entry (including re-entry) holds the divider in clear for one cycle.
    if (go) begin
      state_n  = target;
      div_en_n = 1'b0;
      case (target)
        IDLE:    leds_n = '0;
        CHASE:   leds_n = LED_WIDTH'(1);
        DONE: begin
          leds_n      = ALL_ON;
          flash_cnt_n = '0;
        end
        default: leds_n = ALL_ON;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      leds_o       <= '0;
      flash_cnt    <= '0;
      div_enable_o <= 1'b0;
    end else begin
      state        <= state_n;
      leds_o       <= leds_n;
      flash_cnt    <= flash_cnt_n;
      div_enable_o <= div_en_n;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb/tb_led_pattern_sequencer.sv - randomized self-checking bench for led_pattern_sequencer
module tb_led_pattern_sequencer;

  localparam int W  = 4;
  localparam int DF = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tick_i = 1'b0;
  logic         busy_i = 1'b0;
  logic         done_i = 1'b0;
  logic         error_i = 1'b0;
  logic         error_clear_i = 1'b0;
  logic         div_enable_o;
  logic [W-1:0] leds_o;
  logic [1:0]   state_o;

  int checks   = 0;
  int failures = 0;

  // Reference model: mode, accepted ticks since entry, entry-cycle flag.
  int m_mode  = 0;
  int m_k     = 0;
  bit m_entry = 1'b0;
  int cyc     = 0;

  led_pattern_sequencer #(.LED_WIDTH(W), .DONE_FLASHES(DF)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_i       (tick_i),
    .busy_i       (busy_i),
    .done_i       (done_i),
    .error_i      (error_i),
    .error_clear_i(error_clear_i),
    .div_enable_o (div_enable_o),
    .leds_o       (leds_o),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int m_leds();
    case (m_mode)
      1:       return 1 << (m_k % W);
      2, 3:    return (m_k % 2 == 0) ? ((1 << W) - 1) : 0;
      default: return 0;
    endcase
  endfunction

  task automatic compare();
    expect_eq("state", 32'(state_o), m_mode);
    expect_eq("leds", 32'(leds_o), m_leds());
    expect_eq("div_en", 32'(div_enable_o), (m_mode != 0 && !m_entry) ? 1 : 0);
  endtask

  task automatic m_enter(input int x);
    m_mode  = x;
    m_k     = 0;
    m_entry = (x != 0);
  endtask

  // Drive one cycle of inputs from a negedge, advance the model, check at next negedge.
  task automatic step(input bit b, input bit d, input bit e, input bit c, input bit t);
    bit tok;
    busy_i        = b;
    done_i        = d;
    error_i       = e;
    error_clear_i = c;
    tick_i        = t;
    tok     = t && (m_mode != 0) && !m_entry;
    m_entry = 1'b0;
    if (m_mode == 3) begin
      if (c && !e) m_enter(0);
      else if (tok) m_k++;
    end else if (e) begin
      m_enter(3);
    end else if (d) begin
      m_enter(2);
    end else begin
      case (m_mode)
        0: if (b) m_enter(1);
        1: begin
          if (!b) m_enter(0);
          else if (tok) m_k++;
        end
        2: begin
          if (tok) begin
            if (m_k == 2 * DF - 1) m_enter(b ? 1 : 0);
            else m_k++;
          end
        end
        default: ;
      endcase
    end
    @(posedge clk);
    @(negedge clk);
    compare();
    cyc++;
  endtask

  initial begin
    bit found;
    bit bsy;
    int quiet;

    repeat (2) @(negedge clk);
    compare();
    rst = 1'b0;

    // Drive into CHASE and advance to 0100, then reset asynchronously.
    step(1, 0, 0, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1, 0, 0, 0, (cyc % 4) == 0);
      if (m_mode == 1 && m_leds() == 4) found = 1'b1;
    end
    expect_eq("reach_0100", 32'(found), 1);
    #2 rst = 1'b1;
    #1;
    expect_eq("async_rst_leds", 32'(leds_o), 0);
    expect_eq("async_rst_state", 32'(state_o), 0);
    expect_eq("async_rst_en", 32'(div_enable_o), 0);
    @(negedge clk);
    busy_i = 1'b0;
    tick_i = 1'b0;
    rst    = 1'b0;
    m_mode = 0; m_k = 0; m_entry = 1'b0;
    compare();

    bsy = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      quiet = (i / 400) % 2;
      if ($urandom % 10 == 0) bsy = ~bsy;
      step(bsy,
           ($urandom % (quiet != 0 ? 50 : 10)) == 0,
           ($urandom % (quiet != 0 ? 300 : 40)) == 0,
           ($urandom % 8) == 0,
           (cyc % 4) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
